// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if
//   Control/status bundle for updown_counter_param.
//   Inputs to the counter : clear, load, load_data, enable, up, step, saturate
//   Outputs of the counter: count, wrapped, sat_hit, at_max, at_zero
//   master modport drives the controls; slave modport is the counter itself.
interface updown_counter_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             enable;
    logic             up;
    logic [WIDTH-1:0] step;
    logic             saturate;
    logic [WIDTH-1:0] count;
    logic             wrapped;
    logic             sat_hit;
    logic             at_max;
    logic             at_zero;

    modport master (
        output clear, load, load_data, enable, up, step, saturate,
        input  count, wrapped, sat_hit, at_max, at_zero
    );

    modport slave (
        input  clear, load, load_data, enable, up, step, saturate,
        output count, wrapped, sat_hit, at_max, at_zero
    );
endinterface

// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised up/down counter with modulus MAX_COUNT+1, programmable step,
//   synchronous clear/load, count enable and wrap-or-saturate behaviour.
//   Ports:
//     clock - rising-edge clock
//     reset - asynchronous active-low reset
//     bus   - updown_counter_param_if.slave (controls in, count/flags out)
//   count, wrapped, sat_hit are registered; at_max/at_zero decode count.
module updown_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    updown_counter_param_if.slave bus
);
    // Extended-width constants so all range arithmetic fits without overflow.
    localparam logic [WIDTH:0] MAX_E = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] MOD_E = MAX_E + (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             sat_hit_q, sat_hit_d;

    logic [WIDTH:0]   cnt_e;
    logic [WIDTH:0]   step_e;
    logic [WIDTH:0]   ld_e;
    logic [WIDTH:0]   sum_e;
    logic [WIDTH:0]   res_e;

    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        sat_hit_d = sat_hit_q;
        res_e     = '0;
        sum_e     = '0;

        cnt_e  = {1'b0, count_q};
        ld_e   = {1'b0, bus.load_data};
        step_e = {1'b0, bus.step};
        if (step_e > MAX_E) begin
            step_e = MAX_E;
        end

        if (bus.clear) begin
            count_d   = '0;
            sat_hit_d = 1'b0;
        end else if (bus.load) begin
            res_e     = (ld_e > MAX_E) ? MAX_E : ld_e;
            count_d   = res_e[WIDTH-1:0];
            sat_hit_d = 1'b0;
        end else if (bus.enable) begin
            if (bus.up) begin
                sum_e = cnt_e + step_e;
                if (sum_e <= MAX_E) begin
                    res_e = sum_e;
                end else if (bus.saturate) begin
                    res_e     = MAX_E;
                    sat_hit_d = 1'b1;
                end else begin
                    res_e     = sum_e - MOD_E;
                    wrapped_d = 1'b1;
                end
            end else begin
                if (step_e <= cnt_e) begin
                    res_e = cnt_e - step_e;
                end else if (bus.saturate) begin
                    res_e     = '0;
                    sat_hit_d = 1'b1;
                end else begin
                    // Add the modulus before subtracting so the result never goes negative.
                    res_e     = cnt_e + MOD_E - step_e;
                    wrapped_d = 1'b1;
                end
            end
            count_d = res_e[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            sat_hit_q <= sat_hit_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.wrapped = wrapped_q;
    assign bus.sat_hit = sat_hit_q;
    assign bus.at_max  = (count_q == MAX_E[WIDTH-1:0]);
    assign bus.at_zero = (count_q == '0);
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param
//   Directed bench for updown_counter_param: a decade counter (WIDTH=4,
//   MAX_COUNT=9) and a full-range 8-bit counter share clock and reset.
module tb_updown_counter_param;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    updown_counter_param_if #(.WIDTH(4)) b4 ();
    updown_counter_param_if #(.WIDTH(8)) b8 ();

    updown_counter_param #(.WIDTH(4), .MAX_COUNT(9)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4)
    );

    updown_counter_param #(.WIDTH(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (b8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set4(input logic clr, input logic ld, input logic [3:0] ldd,
                        input logic en, input logic u, input logic [3:0] st,
                        input logic sat);
        b4.clear = clr; b4.load = ld; b4.load_data = ldd;
        b4.enable = en; b4.up = u; b4.step = st; b4.saturate = sat;
    endtask

    task automatic set8(input logic clr, input logic ld, input logic [7:0] ldd,
                        input logic en, input logic u, input logic [7:0] st,
                        input logic sat);
        b8.clear = clr; b8.load = ld; b8.load_data = ldd;
        b8.enable = en; b8.up = u; b8.step = st; b8.saturate = sat;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        set4(0, 0, 4'd0, 0, 1, 4'd1, 0);
        set8(0, 0, 8'd0, 0, 1, 8'd1, 0);
        #12;
        chk("rst_count",   32'(b4.count),   32'd0);
        chk("rst_at_zero", 32'(b4.at_zero), 32'd1);
        chk("rst_at_max",  32'(b4.at_max),  32'd0);
        chk("rst_wrapped", 32'(b4.wrapped), 32'd0);
        chk("rst_sat_hit", 32'(b4.sat_hit), 32'd0);
        chk("rst_count8",  32'(b8.count),   32'd0);
        reset = 1'b1;

        // Load and load clamp
        set4(0, 1, 4'd7, 0, 1, 4'd1, 0);  tick();
        chk("load7", 32'(b4.count), 32'd7);
        set4(0, 1, 4'd12, 0, 1, 4'd1, 0); tick();
        chk("load12_clamp", 32'(b4.count), 32'd9);
        chk("load12_at_max", 32'(b4.at_max), 32'd1);

        // Decade up wrap
        set4(0, 1, 4'd7, 0, 1, 4'd1, 0);  tick();
        set4(0, 0, 4'd0, 1, 1, 4'd1, 0);  tick();
        chk("up_8", 32'(b4.count), 32'd8);
        chk("up_8_wrapped", 32'(b4.wrapped), 32'd0);
        tick();
        chk("up_9", 32'(b4.count), 32'd9);
        chk("up_9_wrapped", 32'(b4.wrapped), 32'd0);
        tick();
        chk("up_wrap_0", 32'(b4.count), 32'd0);
        chk("up_wrap_pulse", 32'(b4.wrapped), 32'd1);
        chk("up_wrap_at_zero", 32'(b4.at_zero), 32'd1);

        // Down wrap with step 3
        set4(0, 1, 4'd2, 1, 1, 4'd1, 0);  tick();
        chk("load2_over_en", 32'(b4.count), 32'd2);
        chk("load2_wrapped", 32'(b4.wrapped), 32'd0);
        set4(0, 0, 4'd0, 1, 0, 4'd3, 0);  tick();
        chk("dn_wrap_9", 32'(b4.count), 32'd9);
        chk("dn_wrap_pulse", 32'(b4.wrapped), 32'd1);
        tick();
        chk("dn_6", 32'(b4.count), 32'd6);
        chk("dn_6_wrapped", 32'(b4.wrapped), 32'd0);

        // Saturate
        set4(0, 1, 4'd8, 0, 1, 4'd1, 0);  tick();
        set4(0, 0, 4'd0, 1, 1, 4'd5, 1);  tick();
        chk("sat_up_9", 32'(b4.count), 32'd9);
        chk("sat_up_hit", 32'(b4.sat_hit), 32'd1);
        chk("sat_up_wrapped", 32'(b4.wrapped), 32'd0);
        set4(0, 0, 4'd0, 1, 0, 4'd8, 1);  tick();
        chk("sat_dn_1", 32'(b4.count), 32'd1);
        chk("sat_hold_hit", 32'(b4.sat_hit), 32'd1);
        set4(0, 0, 4'd0, 1, 0, 4'd4, 1);  tick();
        chk("sat_dn_0", 32'(b4.count), 32'd0);
        chk("sat_dn_hit", 32'(b4.sat_hit), 32'd1);
        set4(0, 1, 4'd5, 0, 1, 4'd1, 0);  tick();
        chk("load_clr_sat", 32'(b4.sat_hit), 32'd0);
        chk("load5", 32'(b4.count), 32'd5);

        // Step larger than MAX_COUNT is clamped to 9: 5+9 = 14 -> 4, wrap
        set4(0, 0, 4'd0, 1, 1, 4'd15, 0); tick();
        chk("bigstep_4", 32'(b4.count), 32'd4);
        chk("bigstep_wrapped", 32'(b4.wrapped), 32'd1);

        // Priority
        set4(0, 1, 4'd5, 0, 1, 4'd1, 0);  tick();
        set4(1, 1, 4'd3, 1, 1, 4'd1, 0);  tick();
        chk("prio_clear", 32'(b4.count), 32'd0);
        set4(0, 1, 4'd3, 1, 1, 4'd1, 0);  tick();
        chk("prio_load", 32'(b4.count), 32'd3);
        set4(0, 0, 4'd0, 0, 1, 4'd1, 0);  tick();
        chk("hold_3", 32'(b4.count), 32'd3);

        // Landing exactly on the limit is not an event
        set4(0, 0, 4'd0, 1, 1, 4'd6, 1);  tick();
        chk("land_max", 32'(b4.count), 32'd9);
        chk("land_max_sat", 32'(b4.sat_hit), 32'd0);
        chk("land_max_wrap", 32'(b4.wrapped), 32'd0);
        set4(0, 0, 4'd0, 1, 1, 4'd0, 0);  tick();
        chk("step0_hold", 32'(b4.count), 32'd9);

        // Async reset mid-count
        set4(0, 1, 4'd5, 0, 1, 4'd1, 0);  tick();
        set4(0, 0, 4'd0, 1, 1, 4'd1, 0);  tick();
        chk("pre_rst_6", 32'(b4.count), 32'd6);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(b4.count), 32'd0);
        chk("async_rst_at_zero", 32'(b4.at_zero), 32'd1);
        reset = 1'b1;
        tick();
        chk("resume_1", 32'(b4.count), 32'd1);
        set4(0, 0, 4'd0, 0, 1, 4'd1, 0);

        // 8-bit full range
        set8(0, 1, 8'd254, 0, 1, 8'd1, 0); tick();
        chk("w8_load254", 32'(b8.count), 32'd254);
        set8(0, 0, 8'd0, 1, 1, 8'd1, 0);   tick();
        chk("w8_255", 32'(b8.count), 32'd255);
        chk("w8_at_max", 32'(b8.at_max), 32'd1);
        tick();
        chk("w8_wrap_0", 32'(b8.count), 32'd0);
        chk("w8_wrap_pulse", 32'(b8.wrapped), 32'd1);
        tick();
        chk("w8_1", 32'(b8.count), 32'd1);
        chk("w8_1_wrapped", 32'(b8.wrapped), 32'd0);
        set8(0, 0, 8'd0, 1, 0, 8'd2, 0);   tick();
        chk("w8_dn_wrap", 32'(b8.count), 32'd255);
        chk("w8_dn_pulse", 32'(b8.wrapped), 32'd1);
        set8(0, 0, 8'd0, 1, 1, 8'd200, 1); tick();
        chk("w8_sat", 32'(b8.count), 32'd255);
        chk("w8_sat_hit", 32'(b8.sat_hit), 32'd1);
        chk("w4_idle", 32'(b4.count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised up/down counter: the successor to the fixed 4-bit load/up/down counter, generalised in width, modulus and step size. It adds a synchronous clear, a count enable, a selectable wrap or saturate mode, terminal-count flags and overflow/underflow reporting. It sits in the same datapath slot as its predecessor and serves as a general event, position or credit counter.

## Interface
- WIDTH, 8: counter width in bits, ≥ 2.
- MAX_COUNT, 2**WIDTH-1: highest legal count value; the count range is 0..MAX_COUNT, so the modulus is MAX_COUNT+1. Legal range 1..2**WIDTH-1.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; asserting it (low) resets all state immediately.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_data.
- load_data  in  WIDTH  value to load.
- enable  in  1  count enable.
- up  in  1  direction: 1 = up, 0 = down.
- step  in  WIDTH  increment/decrement amount.
- saturate  in  1  range-exceed behaviour: 1 = clamp at the limit, 0 = wrap modulo MAX_COUNT+1.
- count  out  WIDTH  registered count.
- wrapped  out  1  registered one-cycle pulse: the previous update wrapped.
- sat_hit  out  1  registered sticky flag: a clamp occurred.
- at_max  out  1  combinational, count == MAX_COUNT.
- at_zero  out  1  combinational, count == 0.

## Operation
- Per rising edge, priority is: clear > load > enable > hold.
- **clear:** count←0, wrapped←0, sat_hit←0.
- **load:**
  - count←min(load_data, MAX_COUNT).
  - wrapped←0, sat_hit←0.
- **enable=0:** count holds, wrapped←0, sat_hit holds.
- **enable=1:**
  - Effective step s = min(step, MAX_COUNT).
  - All arithmetic is done at WIDTH+1 bits; no intermediate overflow is permitted.
  - Up, count+s ≤ MAX_COUNT: count←count+s.
  - Up, exceeds range, saturate=0: count←count+s−(MAX_COUNT+1), wrapped←1.
  - Up, exceeds range, saturate=1: count←MAX_COUNT, sat_hit←1.
  - Down, s ≤ count: count←count−s.
  - Down, exceeds range, saturate=0: count←count+(MAX_COUNT+1)−s, wrapped←1.
  - Down, exceeds range, saturate=1: count←0, sat_hit←1.
  - In any non-exceeding update: wrapped←0, sat_hit holds.
- Landing exactly on MAX_COUNT or 0 is not an exceed event: no wrap and no sat_hit.
- step=0 with enable=1 leaves count unchanged and is not an event.
- saturate and up are sampled per cycle and may change on any cycle.

## Timing
- Reset (reset low): count=0, wrapped=0, sat_hit=0, at_zero=1, at_max=0 (at_max=1 only if MAX_COUNT=0, which is illegal).
- Reset acts asynchronously on assertion. Deassertion is expected synchronous to clock; the first active edge after release applies normal rules.
- Reset asserted mid-count forces the reset values within the same cycle, with no dependence on clock.
- Latency:
  - count, wrapped and sat_hit update one edge after the inputs are sampled.
  - at_max and at_zero follow count combinationally, with zero additional latency.
- wrapped is high for exactly one cycle per wrap event. Back-to-back wraps keep it high on consecutive cycles.
- Simultaneous clear+load+enable: clear wins. load+enable: load wins, and no count is applied that cycle.

## Test plan
- **Reset/load clamp:**
  - WIDTH=4, MAX_COUNT=9; hold reset low → count=0, at_zero=1.
  - Release reset, load=1, load_data=7 → count=7.
  - load_data=12 → count=9, at_max=1.
- **Up wrap, decade:**
  - From 7, up=1, step=1, saturate=0, enable for 3 cycles → 8, 9, 0.
  - wrapped=1 for exactly the cycle count=0.
- **Down wrap with step:**
  - From 2, up=0, step=3, saturate=0 → count=9, wrapped pulse.
  - Next cycle → 6, wrapped=0.
- **Saturate:**
  - From 8, up=1, step=5, saturate=1 → count=9, sat_hit=1.
  - Down from 1 with step=4 → count=0, sat_hit stays 1.
  - load → sat_hit=0.
- **Priority:**
  - From 5, assert clear+load(3)+enable together → count=0.
  - Next cycle, load(3)+enable up step=1 → count=3, not 4.
- **Async reset mid-count:**
  - While counting up at 6, drive reset low between edges → count=0 immediately, before the next edge.
  - Release → counting resumes from 0.
  - Repeat the directed cases with WIDTH=8 at default MAX_COUNT: 255+1 → 0 with a wrapped pulse.
